// File: rtl/claim_checker.sv
// rtl/claim_checker.sv - framed claim packet checksum verifier driving truth_detection
module claim_checker #(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              truth_detection,
    output logic              verdict_valid,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BODY  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] chk;
    logic [LEN_W-1:0]  len;
    logic              ovf;
    logic              accept;
    logic              good;

    assign accept = in_valid && in_ready;
    assign good   = (chk == sum) && (len != '0) && !ovf;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = in_last ? S_CHECK : S_BODY;
                end
            end
            S_BODY: begin
                if (accept && in_last) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state != S_CHECK);
    end

    // Accumulators, verdict register and saturating statistics.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sum             <= '0;
            chk             <= '0;
            len             <= '0;
            ovf             <= 1'b0;
            truth_detection <= 1'b0;
            verdict_valid   <= 1'b0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
        end else begin
            verdict_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (in_last) begin
                            chk <= in_data;
                        end else begin
                            sum <= in_data;
                            len <= LEN_W'(1);
                        end
                    end
                end
                S_BODY: begin
                    if (accept) begin
                        if (in_last) begin
                            chk <= in_data;
                        end else begin
                            sum <= sum + in_data;
                            if (len == LEN_W'(MAX_LEN)) begin
                                ovf <= 1'b1;
                            end else begin
                                len <= len + LEN_W'(1);
                            end
                        end
                    end
                end
                S_CHECK: begin
                    truth_detection <= good;
                    verdict_valid   <= 1'b1;
                    if (good) begin
                        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                    end
                    sum <= '0;
                    chk <= '0;
                    len <= '0;
                    ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_claim_checker.sv
// tb/tb_claim_checker.sv - packet table plus scoreboard bench for claim_checker
module tb_claim_checker;

    localparam int DW = 8;
    localparam int ML = 16;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int NPK = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          truth_detection;
    logic          verdict_valid;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;

    claim_checker #(.DATA_W(DW), .MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk(clk),
        .rstn(rstn),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_last(in_last),
        .in_ready(in_ready),
        .truth_detection(truth_detection),
        .verdict_valid(verdict_valid),
        .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic good;
        int   edge_no;
    } exp_t;

    typedef struct {
        int            n;
        logic [DW-1:0] body[20];
        logic [DW-1:0] last;
        logic          good;
    } pkt_t;

    exp_t sbq[$];
    exp_t e_mon;
    pkt_t pk[NPK];
    int   total = 0;
    int   bad = 0;
    int   m_pass = 0;
    int   m_fail = 0;
    int   n_verdicts = 0;
    logic prev_vv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every verdict strobe pops one expectation.
    always @(negedge clk) begin
        if (!rstn) begin
            m_pass = 0;
            m_fail = 0;
            sbq.delete();
        end else if (verdict_valid) begin
            n_verdicts++;
            check("vv_one_cycle", {31'd0, prev_vv}, 0);
            if (sbq.size() == 0) begin
                check("spurious_verdict", 1, 0);
            end else begin
                e_mon = sbq.pop_front();
                check("truth", {31'd0, truth_detection}, {31'd0, e_mon.good});
                check("verdict_edge", cyc, e_mon.edge_no);
                if (e_mon.good) begin
                    if (m_pass < CMAX) m_pass++;
                end else begin
                    if (m_fail < CMAX) m_fail++;
                end
                check("pass_cnt", {30'd0, pass_cnt}, m_pass);
                check("fail_cnt", {30'd0, fail_cnt}, m_fail);
            end
        end
        prev_vv = verdict_valid;
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l, input int gap, input logic exp_good);
        int budget = 0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && budget < 8) begin
            @(negedge clk);
            budget++;
        end
        check("ready_for_beat", {31'd0, in_ready}, 1);
        if (l) sbq.push_back('{good: exp_good, edge_no: cyc + 2});
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (l) check("ready_low_in_check", {31'd0, in_ready}, 0);
    endtask

    task automatic send_pkt(input pkt_t p, input int max_gap);
        for (int i = 0; i < p.n; i++) send_beat(p.body[i], 1'b0, $urandom_range(0, max_gap), 1'b0);
        send_beat(p.last, 1'b1, $urandom_range(0, max_gap), p.good);
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        #1 rstn = 1'b0;
        repeat (n) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        int b = 0;
        while (sbq.size() > 0 && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("drain", sbq.size(), 0);
    endtask

    initial begin
        pkt_t p;
        int   nv0;
        logic [DW-1:0] a;
        logic [DW-1:0] c;

        for (int k = 0; k < NPK; k++) begin
            pk[k].n = 0;
            pk[k].last = '0;
            pk[k].good = 1'b0;
            for (int j = 0; j < 20; j++) pk[k].body[j] = '0;
        end
        pk[0].n = 3; pk[0].body[0] = 8'h01; pk[0].body[1] = 8'h02; pk[0].body[2] = 8'h03;
        pk[0].last = 8'h06; pk[0].good = 1'b1;
        pk[1].n = 2; pk[1].body[0] = 8'hFF; pk[1].body[1] = 8'h02; pk[1].last = 8'h01; pk[1].good = 1'b1;
        pk[2].n = 2; pk[2].body[0] = 8'hFF; pk[2].body[1] = 8'h02; pk[2].last = 8'h02; pk[2].good = 1'b0;
        pk[3].n = 16; pk[3].last = 8'h00; pk[3].good = 1'b1;
        pk[4].n = 17; pk[4].last = 8'h00; pk[4].good = 1'b0;
        pk[5].n = 0; pk[5].last = 8'h00; pk[5].good = 1'b0;
        pk[6].n = 1; pk[6].body[0] = 8'h80; pk[6].last = 8'h81; pk[6].good = 1'b0;
        pk[7].n = 4; pk[7].body[0] = 8'h10; pk[7].body[1] = 8'h20; pk[7].body[2] = 8'h30;
        pk[7].body[3] = 8'h40; pk[7].last = 8'hA0; pk[7].good = 1'b1;

        apply_reset(2);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_truth", {31'd0, truth_detection}, 0);
        check("rst_vv", {31'd0, verdict_valid}, 0);
        check("rst_pass", {30'd0, pass_cnt}, 0);
        check("rst_fail", {30'd0, fail_cnt}, 0);

        for (int k = 0; k < NPK; k++) send_pkt(pk[k], 0);
        drain();

        // A beat offered during CHECK must be ignored; a lone 0x55 checksum is then a fail.
        apply_reset(1);
        send_pkt(pk[0], 0);
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
        check("ready_low_offer", {31'd0, in_ready}, 0);
        @(negedge clk);
        in_valid = 1'b0;
        send_beat(8'h55, 1'b1, 0, 1'b0);
        drain();
        check("truth_held", {31'd0, truth_detection}, 0);

        apply_reset(1);
        send_beat(8'h10, 1'b0, 0, 1'b0);
        send_beat(8'h20, 1'b0, 0, 1'b0);
        apply_reset(1);
        nv0 = n_verdicts;
        send_beat(8'h05, 1'b0, 0, 1'b0);
        send_beat(8'h05, 1'b1, 0, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        check("one_verdict_after_rst", n_verdicts - nv0, 1);
        check("midrst_pass", {30'd0, pass_cnt}, 1);
        check("midrst_fail", {30'd0, fail_cnt}, 0);
        check("midrst_truth", {31'd0, truth_detection}, 1);

        apply_reset(1);
        for (int k = 0; k < 5; k++) begin
            a = DW'($urandom_range(0, 255));
            c = DW'($urandom_range(0, 255));
            p = pk[5];
            p.n = 2; p.body[0] = a; p.body[1] = c;
            p.last = a + c + 8'h01; p.good = 1'b0;
            send_pkt(p, 3);
        end
        drain();
        check("fail_saturated", {30'd0, fail_cnt}, CMAX);
        for (int k = 0; k < 4; k++) send_pkt(pk[7], 2);
        drain();
        check("pass_saturated", {30'd0, pass_cnt}, CMAX);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
